// File: rtl/float_pkg.sv
// Shared constants and state encoding for the single-precision float units
// (multiplier and float_sub_1d5).
package float_pkg;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;
  localparam int BIAS       = 127;
  localparam int SIG_W      = MANT_W + 1;
  localparam int ACC_W      = 2 * SIG_W;
  localparam int CNT_W      = 5;
  localparam int EXP_SUM_W  = 10;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_FINISH
  } state_t;
endpackage

// File: rtl/fmul_classify.sv
// Combinational decode of one IEEE-754 single operand into zero/inf/nan classes.
// Denormals report as zero since they are flushed by the multiplier.
module fmul_classify
  import float_pkg::*;
(
  input  logic [31:0] op,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);
  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] frac_f;

  assign exp_f   = op[30:23];
  assign frac_f  = op[22:0];
  assign is_zero = (exp_f == '0);
  assign is_inf  = (exp_f == {EXP_W{1'b1}}) && (frac_f == '0);
  assign is_nan  = (exp_f == {EXP_W{1'b1}}) && (frac_f != '0);
endmodule

// File: rtl/float_mul_seq.sv
// Sequential single-precision multiplier, 1 mantissa bit per clock; ready pulses 27 edges
// after start is sampled. start is only accepted in IDLE; no queueing.
module float_mul_seq
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] float_out,
  output logic        ready
);
  state_t                       state;
  logic                         sign;
  logic [SIG_W-1:0]             ma;
  logic [SIG_W-1:0]             mb;
  logic signed [EXP_SUM_W-1:0]  exp_sum;
  logic [ACC_W-1:0]             acc;
  logic [CNT_W-1:0]             cnt;
  logic [MANT_W-1:0]            frac;
  logic                         guard;
  logic                         nan_f;
  logic                         inf_f;
  logic                         zero_f;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  fmul_classify u_cls_a (.op(a_in), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  fmul_classify u_cls_b (.op(b_in), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

  logic [ACC_W-1:0]  partial;
  logic [MANT_W:0]   frac_rnd;
  logic [31:0]       result;

  always_comb begin
    partial  = mb[cnt] ? ({{SIG_W{1'b0}}, ma} << cnt) : '0;
    frac_rnd = {1'b0, frac} + {{MANT_W{1'b0}}, guard};
  end

  // Special classes override the datapath; inf*zero is folded into nan_f at latch time.
  always_comb begin
    result = {sign, exp_sum[EXP_W-1:0], frac};
    if (nan_f)
      result = QNAN;
    else if (inf_f)
      result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    else if (zero_f)
      result = {sign, 31'b0};
    else if (exp_sum >= 10'sd255)
      result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    else if (exp_sum <= 10'sd0)
      result = {sign, 31'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      float_out <= '0;
      ready     <= 1'b0;
      sign      <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      exp_sum   <= '0;
      acc       <= '0;
      cnt       <= '0;
      frac      <= '0;
      guard     <= 1'b0;
      nan_f     <= 1'b0;
      inf_f     <= 1'b0;
      zero_f    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 1'b0;
          if (start) begin
            sign    <= a_in[31] ^ b_in[31];
            ma      <= {1'b1, a_in[22:0]};
            mb      <= {1'b1, b_in[22:0]};
            exp_sum <= $signed({2'b00, a_in[30:23]}) + $signed({2'b00, b_in[30:23]})
                       - EXP_SUM_W'(BIAS);
            nan_f   <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
            inf_f   <= a_inf | b_inf;
            zero_f  <= a_zero | b_zero;
            acc     <= '0;
            cnt     <= '0;
            state   <= S_MUL;
          end
        end
        S_MUL: begin
          acc <= acc + partial;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(SIG_W - 1))
            state <= S_NORM;
        end
        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4); bit 47 selects the binade.
          if (acc[ACC_W-1]) begin
            frac    <= acc[ACC_W-2:SIG_W];
            guard   <= acc[SIG_W-1];
            exp_sum <= exp_sum + 1'b1;
          end else begin
            frac    <= acc[ACC_W-3:SIG_W-1];
            guard   <= acc[SIG_W-2];
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          if (frac_rnd[MANT_W]) begin
            frac    <= '0;
            exp_sum <= exp_sum + 1'b1;
          end else begin
            frac    <= frac_rnd[MANT_W-1:0];
          end
          state <= S_FINISH;
        end
        S_FINISH: begin
          float_out <= result;
          ready     <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_mul_seq.sv
// Bench for float_mul_seq: vector table plus handshake, abort and reset sequences,
// with a queue of expected results and due cycles.
module tb_float_mul_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] float_out;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    int          due;
  } sb_t;

  vec_t vecs[12];
  sb_t  sb[$];

  float_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .float_out (float_out),
    .ready     (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called at a negedge; start is sampled by the following posedge, and the result
  // must be visible at the negedge after the 27th edge from there.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] e);
    sb_t item;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    if (push) begin
      item.val = e;
      item.due = cyc + 28;
      sb.push_back(item);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int  n;
    sb_t e;
    n = 0;
    while (ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: ready timeout, ready=%b expected 1", name, ready);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected ready, out=%h expected no result", name, float_out);
    end else begin
      e = sb.pop_front();
      check(name, float_out, e.val);
      check({name, "_latency"}, 32'(cyc), 32'(e.due));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000};
    vecs[1]  = '{32'h3F000000, 32'hBF800000, 32'hBF000000};
    vecs[2]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002};
    vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000};
    vecs[5]  = '{32'h80000000, 32'h40400000, 32'h80000000};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[7]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
    vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000};
    vecs[9]  = '{32'h40400000, 32'h40400000, 32'h41100000};
    vecs[10] = '{32'h3F842108, 32'h3FF80000, 32'h40000000};
    vecs[11] = '{32'h00400000, 32'hC0000000, 32'h80000000};

    repeat (2) @(negedge clk);
    check("reset_out", float_out, 32'h0);
    check("reset_ready", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
      wait_result($sformatf("vec%0d", i));
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("hold_out", float_out, vecs[11].exp);
    check("hold_ready", {31'b0, ready}, 32'h0);

    // A start pulse while multiplying must not disturb the running operation.
    drive(32'h40400000, 32'h40400000, 1'b1, 32'h41100000);
    repeat (5) @(negedge clk);
    drive(32'h3F800000, 32'h3F800000, 1'b0, 32'h0);
    wait_result("ignore_mid_mul");

    // New start on the ready cycle is accepted; ready drops on the next edge.
    drive(32'h3F000000, 32'hBF800000, 1'b1, 32'hBF000000);
    check("ready_drop", {31'b0, ready}, 32'h0);
    wait_result("back_to_back");
    @(negedge clk);

    // Asynchronous reset in the middle of MUL, away from any edge.
    drive(32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", float_out, 32'h0);
    check("async_rst_ready", {31'b0, ready}, 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100002);
    wait_result("post_reset");

    repeat (40) @(negedge clk);
    check("no_extra_ready", {31'b0, ready}, 32'h0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
